// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states, forwarding
// selects, load write-back encoding and the forwarding compare helper.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } hz_state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    localparam logic [1:0] LOAD_SEL_ENC = 2'b01;

    // The newest producer (MEM) wins over WB; x0 is never forwarded.
    function automatic logic [1:0] fwd_pick(
        input logic [4:0] rs,
        input logic       we_mem,
        input logic [4:0] rd_mem,
        input logic       we_wb,
        input logic [4:0] rd_wb
    );
        logic [1:0] sel;
        if (we_mem && (rd_mem != 5'd0) && (rd_mem == rs)) begin
            sel = FWD_MEM;
        end else if (we_wb && (rd_wb != 5'd0) && (rd_wb == rs)) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// Combinational EX-stage operand forwarding selects for both ALU sources.
module fwd_unit
    import hazard_ctrl_pkg::*;
(
    input  logic [4:0] Rs1_addr_EX,
    input  logic [4:0] Rs2_addr_EX,
    input  logic [4:0] Rd_addr_MEM,
    input  logic       RegWrite_MEM,
    input  logic [4:0] Rd_addr_WB,
    input  logic       RegWrite_WB,
    output logic [1:0] fwdA_EX,
    output logic [1:0] fwdB_EX
);

    // Independent compare for each source operand.
    always_comb begin
        fwdA_EX = fwd_pick(Rs1_addr_EX, RegWrite_MEM, Rd_addr_MEM, RegWrite_WB, Rd_addr_WB);
        fwdB_EX = fwd_pick(Rs2_addr_EX, RegWrite_MEM, Rd_addr_MEM, RegWrite_WB, Rd_addr_WB);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32 pipeline: stage enables, flush/bubble,
// memory-wait freeze with timeout FSM, and saturating hazard counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int         TIMEOUT  = 64,
    parameter int         CW       = 32,
    parameter logic [1:0] LOAD_SEL = LOAD_SEL_ENC
)(
    input  logic          clk_IDEX,
    input  logic          rst_IDEX,
    input  logic [4:0]    Rs1_addr_ID,
    input  logic [4:0]    Rs2_addr_ID,
    input  logic          Rs1_used_ID,
    input  logic          Rs2_used_ID,
    input  logic [4:0]    Rs1_addr_EX,
    input  logic [4:0]    Rs2_addr_EX,
    input  logic [4:0]    Rd_addr_EX,
    input  logic          RegWrite_EX,
    input  logic [1:0]    MemtoReg_EX,
    input  logic          Branch_taken_EX,
    input  logic [4:0]    Rd_addr_MEM,
    input  logic          RegWrite_MEM,
    input  logic [4:0]    Rd_addr_WB,
    input  logic          RegWrite_WB,
    input  logic          mem_req_MEM,
    input  logic          mem_ready,
    input  logic          clr_cnt,
    output logic          en_PC,
    output logic          en_IFID,
    output logic          en_IDEX,
    output logic          en_EXMEM,
    output logic          en_MEMWB,
    output logic          flush_IFID,
    output logic          bubble_IDEX,
    output logic [1:0]    fwdA_EX,
    output logic [1:0]    fwdB_EX,
    output logic          mem_timeout,
    output logic [CW-1:0] stall_cnt,
    output logic [CW-1:0] flush_cnt,
    output logic [CW-1:0] freeze_cnt
);

    localparam int            WW        = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};

    hz_state_e     state_r, state_s;
    logic [WW-1:0] wait_cnt_r, wait_cnt_s;
    logic          mem_timeout_r, mem_timeout_s;
    logic [CW-1:0] stall_cnt_r, flush_cnt_r, freeze_cnt_r;
    logic          freeze_s, lu_s, stall_ev_s, flush_ev_s;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CNT_MAX) ? v : v + CW'(1);
    endfunction

    fwd_unit u_fwd (
        .Rs1_addr_EX  (Rs1_addr_EX),
        .Rs2_addr_EX  (Rs2_addr_EX),
        .Rd_addr_MEM  (Rd_addr_MEM),
        .RegWrite_MEM (RegWrite_MEM),
        .Rd_addr_WB   (Rd_addr_WB),
        .RegWrite_WB  (RegWrite_WB),
        .fwdA_EX      (fwdA_EX),
        .fwdB_EX      (fwdB_EX)
    );

    // Hazard detection terms.
    always_comb begin
        freeze_s = (mem_req_MEM & ~mem_ready) | (state_r == ERROR);
        lu_s     = RegWrite_EX & (MemtoReg_EX == LOAD_SEL) & (Rd_addr_EX != 5'd0) &
                   ((Rs1_used_ID & (Rs1_addr_ID == Rd_addr_EX)) |
                    (Rs2_used_ID & (Rs2_addr_ID == Rd_addr_EX)));
    end

    // Priority freeze > branch > load-use > normal; losers are deferred because inputs hold.
    always_comb begin
        en_PC       = 1'b1;
        en_IFID     = 1'b1;
        en_IDEX     = 1'b1;
        en_EXMEM    = 1'b1;
        en_MEMWB    = 1'b1;
        flush_IFID  = 1'b0;
        bubble_IDEX = 1'b0;
        stall_ev_s  = 1'b0;
        flush_ev_s  = 1'b0;
        if (freeze_s) begin
            en_PC    = 1'b0;
            en_IFID  = 1'b0;
            en_IDEX  = 1'b0;
            en_EXMEM = 1'b0;
            en_MEMWB = 1'b0;
        end else if (Branch_taken_EX) begin
            flush_IFID  = 1'b1;
            bubble_IDEX = 1'b1;
            flush_ev_s  = 1'b1;
        end else if (lu_s) begin
            en_PC       = 1'b0;
            en_IFID     = 1'b0;
            bubble_IDEX = 1'b1;
            stall_ev_s  = 1'b1;
        end else begin
            flush_IFID  = 1'b0;
        end
    end

    // Memory-wait FSM next state; a ready on the limit cycle wins over the timeout.
    always_comb begin
        state_s       = state_r;
        wait_cnt_s    = wait_cnt_r;
        mem_timeout_s = mem_timeout_r;
        case (state_r)
            RUN: begin
                if (mem_req_MEM && !mem_ready) begin
                    state_s    = MEM_WAIT;
                    wait_cnt_s = WW'(1);
                end else begin
                    wait_cnt_s = '0;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_s    = RUN;
                    wait_cnt_s = '0;
                end else if (wait_cnt_r == WAIT_LAST) begin
                    state_s       = ERROR;
                    mem_timeout_s = 1'b1;
                end else begin
                    wait_cnt_s = wait_cnt_r + WW'(1);
                end
            end
            ERROR: begin
                state_s = ERROR;
            end
            default: begin
                state_s    = RUN;
                wait_cnt_s = '0;
            end
        endcase
    end

    // FSM state, wait counter and sticky timeout flag.
    always_ff @(posedge clk_IDEX or posedge rst_IDEX) begin
        if (rst_IDEX) begin
            state_r       <= RUN;
            wait_cnt_r    <= '0;
            mem_timeout_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            wait_cnt_r    <= wait_cnt_s;
            mem_timeout_r <= mem_timeout_s;
        end
    end

    // Saturating performance counters; clr_cnt beats any increment.
    always_ff @(posedge clk_IDEX or posedge rst_IDEX) begin
        if (rst_IDEX) begin
            stall_cnt_r  <= '0;
            flush_cnt_r  <= '0;
            freeze_cnt_r <= '0;
        end else if (clr_cnt) begin
            stall_cnt_r  <= '0;
            flush_cnt_r  <= '0;
            freeze_cnt_r <= '0;
        end else begin
            if (stall_ev_s) stall_cnt_r  <= sat_inc(stall_cnt_r);
            if (flush_ev_s) flush_cnt_r  <= sat_inc(flush_cnt_r);
            if (freeze_s)   freeze_cnt_r <= sat_inc(freeze_cnt_r);
        end
    end

    assign mem_timeout = mem_timeout_r;
    assign stall_cnt   = stall_cnt_r;
    assign flush_cnt   = flush_cnt_r;
    assign freeze_cnt  = freeze_cnt_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (TIMEOUT=4, CW=4 so timeout and
// counter saturation are reachable quickly).
module tb_hazard_ctrl;

    localparam int CW = 4;

    logic          clk_IDEX = 1'b0;
    logic          rst_IDEX;
    logic [4:0]    Rs1_addr_ID, Rs2_addr_ID, Rs1_addr_EX, Rs2_addr_EX;
    logic          Rs1_used_ID, Rs2_used_ID;
    logic [4:0]    Rd_addr_EX, Rd_addr_MEM, Rd_addr_WB;
    logic          RegWrite_EX, RegWrite_MEM, RegWrite_WB;
    logic [1:0]    MemtoReg_EX;
    logic          Branch_taken_EX, mem_req_MEM, mem_ready, clr_cnt;
    logic          en_PC, en_IFID, en_IDEX, en_EXMEM, en_MEMWB;
    logic          flush_IFID, bubble_IDEX, mem_timeout;
    logic [1:0]    fwdA_EX, fwdB_EX;
    logic [CW-1:0] stall_cnt, flush_cnt, freeze_cnt;

    int checks   = 0;
    int failures = 0;

    hazard_ctrl #(.TIMEOUT(4), .CW(CW), .LOAD_SEL(2'b01)) dut (
        .clk_IDEX(clk_IDEX), .rst_IDEX(rst_IDEX),
        .Rs1_addr_ID(Rs1_addr_ID), .Rs2_addr_ID(Rs2_addr_ID),
        .Rs1_used_ID(Rs1_used_ID), .Rs2_used_ID(Rs2_used_ID),
        .Rs1_addr_EX(Rs1_addr_EX), .Rs2_addr_EX(Rs2_addr_EX),
        .Rd_addr_EX(Rd_addr_EX), .RegWrite_EX(RegWrite_EX), .MemtoReg_EX(MemtoReg_EX),
        .Branch_taken_EX(Branch_taken_EX),
        .Rd_addr_MEM(Rd_addr_MEM), .RegWrite_MEM(RegWrite_MEM),
        .Rd_addr_WB(Rd_addr_WB), .RegWrite_WB(RegWrite_WB),
        .mem_req_MEM(mem_req_MEM), .mem_ready(mem_ready), .clr_cnt(clr_cnt),
        .en_PC(en_PC), .en_IFID(en_IFID), .en_IDEX(en_IDEX),
        .en_EXMEM(en_EXMEM), .en_MEMWB(en_MEMWB),
        .flush_IFID(flush_IFID), .bubble_IDEX(bubble_IDEX),
        .fwdA_EX(fwdA_EX), .fwdB_EX(fwdB_EX), .mem_timeout(mem_timeout),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .freeze_cnt(freeze_cnt)
    );

    always #5 clk_IDEX = ~clk_IDEX;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_IDEX);
        #1;
    endtask

    function automatic logic [31:0] ens();
        return 32'({en_PC, en_IFID, en_IDEX, en_EXMEM, en_MEMWB});
    endfunction

    function automatic logic [31:0] fb();
        return 32'({flush_IFID, bubble_IDEX});
    endfunction

    initial begin
        rst_IDEX = 1'b1;
        Rs1_addr_ID = 5'd0; Rs2_addr_ID = 5'd0; Rs1_used_ID = 1'b0; Rs2_used_ID = 1'b0;
        Rs1_addr_EX = 5'd0; Rs2_addr_EX = 5'd0; Rd_addr_EX = 5'd0;
        RegWrite_EX = 1'b0; MemtoReg_EX = 2'b00; Branch_taken_EX = 1'b0;
        Rd_addr_MEM = 5'd0; RegWrite_MEM = 1'b0; Rd_addr_WB = 5'd0; RegWrite_WB = 1'b0;
        mem_req_MEM = 1'b0; mem_ready = 1'b0; clr_cnt = 1'b0;
        #3;
        chk("rst_en", ens(), 32'h1f);
        chk("rst_fb", fb(), 32'h0);
        chk("rst_fwd", 32'({fwdA_EX, fwdB_EX}), 32'h0);
        chk("rst_cnt", 32'({stall_cnt, flush_cnt, freeze_cnt}), 32'h0);
        chk("rst_tmo", 32'(mem_timeout), 32'h0);
        #9 rst_IDEX = 1'b0;
        tick();

        // Load-use on Rs1: one stall cycle
        RegWrite_EX = 1'b1; MemtoReg_EX = 2'b01; Rd_addr_EX = 5'd5;
        Rs1_addr_ID = 5'd5; Rs1_used_ID = 1'b1;
        #1;
        chk("lu_en", ens(), 32'h07);
        chk("lu_fb", fb(), 32'h1);
        tick();
        RegWrite_EX = 1'b0; MemtoReg_EX = 2'b00; Rd_addr_EX = 5'd0;
        #1;
        chk("lu_after_en", ens(), 32'h1f);
        chk("lu_after_fb", fb(), 32'h0);
        chk("lu_stall_cnt", 32'(stall_cnt), 32'h1);

        // Same load but source not actually read: no stall
        RegWrite_EX = 1'b1; MemtoReg_EX = 2'b01; Rd_addr_EX = 5'd5; Rs1_used_ID = 1'b0;
        #1;
        chk("lu_unused_en", ens(), 32'h1f);
        // Non-load writer (MemtoReg=00) on a used source: no stall
        Rs1_used_ID = 1'b1; MemtoReg_EX = 2'b00;
        #1;
        chk("lu_nonload_en", ens(), 32'h1f);
        // Load-use via Rs2
        MemtoReg_EX = 2'b01; Rs1_used_ID = 1'b0; Rs2_addr_ID = 5'd5; Rs2_used_ID = 1'b1;
        #1;
        chk("lu_rs2_en", ens(), 32'h07);
        Rs2_used_ID = 1'b0; Rs2_addr_ID = 5'd0; RegWrite_EX = 1'b0;
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        chk("clr_stall_cnt", 32'(stall_cnt), 32'h0);

        // Load to x0: never a hazard
        RegWrite_EX = 1'b1; MemtoReg_EX = 2'b01; Rd_addr_EX = 5'd0;
        Rs1_addr_ID = 5'd0; Rs1_used_ID = 1'b1;
        #1;
        chk("x0_en", ens(), 32'h1f);
        chk("x0_fb", fb(), 32'h0);
        tick();
        chk("x0_stall_cnt", 32'(stall_cnt), 32'h0);

        // Branch taken together with load-use: branch wins
        Rd_addr_EX = 5'd5; Rs1_addr_ID = 5'd5; Branch_taken_EX = 1'b1;
        #1;
        chk("br_en", ens(), 32'h1f);
        chk("br_fb", fb(), 32'h3);
        tick();
        chk("br_flush_cnt", 32'(flush_cnt), 32'h1);
        chk("br_stall_cnt", 32'(stall_cnt), 32'h0);
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        chk("clr_prio_flush_cnt", 32'(flush_cnt), 32'h0);
        Branch_taken_EX = 1'b0;

        // Memory wait for 3 cycles with a pending load-use held behind the freeze
        mem_req_MEM = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("wait_en", ens(), 32'h00);
            chk("wait_fb", fb(), 32'h0);
            tick();
        end
        chk("wait_freeze_cnt", 32'(freeze_cnt), 32'h3);
        chk("wait_stall_cnt", 32'(stall_cnt), 32'h0);
        // Ready arrives exactly when wait_cnt reaches the limit: ready wins
        mem_ready = 1'b1;
        #1;
        chk("ready_en", ens(), 32'h07);
        chk("ready_fb", fb(), 32'h1);
        tick();
        mem_req_MEM = 1'b0; mem_ready = 1'b0;
        RegWrite_EX = 1'b0; Rd_addr_EX = 5'd0; Rs1_used_ID = 1'b0; Rs1_addr_ID = 5'd0;
        tick();
        chk("resume_en", ens(), 32'h1f);
        chk("resume_freeze_cnt", 32'(freeze_cnt), 32'h3);
        chk("resume_stall_cnt", 32'(stall_cnt), 32'h1);
        chk("resume_tmo", 32'(mem_timeout), 32'h0);

        // Timeout: four unanswered wait cycles
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        mem_req_MEM = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("tmo_pending", 32'(mem_timeout), 32'h0);
            tick();
        end
        chk("tmo_set", 32'(mem_timeout), 32'h1);
        mem_req_MEM = 1'b0; mem_ready = 1'b1;
        #1;
        chk("err_en", ens(), 32'h00);

        // Forwarding is independent of the freeze
        Rs1_addr_EX = 5'd7; RegWrite_MEM = 1'b1; Rd_addr_MEM = 5'd7;
        RegWrite_WB = 1'b1; Rd_addr_WB = 5'd7; Rs2_addr_EX = 5'd3;
        #1;
        chk("fwd_mem_prio", 32'({fwdA_EX, fwdB_EX}), 32'h8);
        Rd_addr_WB = 5'd3;
        #1;
        chk("fwd_wb_b", 32'({fwdA_EX, fwdB_EX}), 32'h9);
        Rs1_addr_EX = 5'd0; Rd_addr_MEM = 5'd0; Rd_addr_WB = 5'd0;
        #1;
        chk("fwd_x0", 32'({fwdA_EX, fwdB_EX}), 32'h0);
        Rs1_addr_EX = 5'd7; RegWrite_MEM = 1'b0; Rd_addr_MEM = 5'd7; Rd_addr_WB = 5'd7;
        #1;
        chk("fwd_wb_a", 32'(fwdA_EX), 32'h1);

        // ERROR holds the freeze; freeze_cnt saturates at 15
        for (int i = 0; i < 15; i++) tick();
        chk("err_hold_en", ens(), 32'h00);
        chk("err_hold_tmo", 32'(mem_timeout), 32'h1);
        chk("freeze_sat", 32'(freeze_cnt), 32'hf);

        // Asynchronous reset between edges clears everything at once
        #2 rst_IDEX = 1'b1;
        #1;
        chk("arst_tmo", 32'(mem_timeout), 32'h0);
        chk("arst_en", ens(), 32'h1f);
        chk("arst_cnt", 32'({stall_cnt, flush_cnt, freeze_cnt}), 32'h0);
        #2 rst_IDEX = 1'b0;
        mem_ready = 1'b0;
        tick();
        chk("post_rst_en", ens(), 32'h1f);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage RV32 core. It is the producer side of the ID/EX stage-register interface.
- Drives en_IDEX and the ID/EX bubble select, plus the enables and flushes of the PC and the other stage registers.
- Generates EX-stage forwarding selects, freezes the pipeline on data-memory wait, and detects a memory timeout.
- Holds saturating hazard performance counters.

Parameters:
- TIMEOUT, 64: maximum consecutive memory-wait cycles before error.
- CW, 32: width of each performance counter.
- LOAD_SEL, 2'b01: MemtoReg encoding that marks a load.

Ports:
- clk_IDEX  in  1  pipeline clock
- rst_IDEX  in  1  reset; asynchronous, active-high
- Rs1_addr_ID, Rs2_addr_ID  in  5  source registers of the instruction in ID
- Rs1_used_ID, Rs2_used_ID  in  1  the instruction in ID reads that source
- Rs1_addr_EX, Rs2_addr_EX  in  5  source registers of the instruction in EX
- Rd_addr_EX  in  5  destination register in EX
- RegWrite_EX  in  1  EX instruction writes Rd
- MemtoReg_EX  in  2  EX instruction write-back select
- Branch_taken_EX  in  1  branch or jump resolved taken in EX
- Rd_addr_MEM  in  5  destination register in MEM
- RegWrite_MEM  in  1  MEM instruction writes Rd
- Rd_addr_WB  in  5  destination register in WB
- RegWrite_WB  in  1  WB instruction writes Rd
- mem_req_MEM  in  1  load/store access in MEM
- mem_ready  in  1  data memory completes the access this cycle
- clr_cnt  in  1  synchronous clear of the counters
- en_PC, en_IFID, en_IDEX, en_EXMEM, en_MEMWB  out  1  stage enables
- flush_IFID  out  1  load a NOP into IF/ID
- bubble_IDEX  out  1  force ID/EX control inputs to 0 this cycle
- fwdA_EX, fwdB_EX  out  2  forwarding select: 00 register file, 10 MEM, 01 WB
- mem_timeout  out  1  sticky error flag
- stall_cnt, flush_cnt, freeze_cnt  out  CW  performance counters

Behaviour:
- State: FSM {RUN, MEM_WAIT, ERROR}; wait_cnt is 7 bits (sized to TIMEOUT); three counters.
- Reset (async): state RUN, wait_cnt 0, counters 0, mem_timeout 0.
  - Outputs are combinational from state and inputs. With idle inputs after reset, all en_* = 1, flush/bubble = 0, fwd = 00.
- freeze = (mem_req_MEM & ~mem_ready) | (state == ERROR).
- Load-use hazard lu:
  - Condition: RegWrite_EX & MemtoReg_EX == LOAD_SEL & Rd_addr_EX != 0.
  - And either (Rs1_used_ID & Rs1_addr_ID == Rd_addr_EX) or (Rs2_used_ID & Rs2_addr_ID == Rd_addr_EX).
- Output priority is freeze > Branch_taken_EX > lu > normal:
  - freeze: all en_* = 0; flush_IFID = 0; bubble_IDEX = 0. Branch and lu are deferred, not lost, because the inputs are held stable.
  - branch: all en_* = 1; flush_IFID = 1; bubble_IDEX = 1. A simultaneous lu is ignored because the ID instruction is squashed.
  - lu: en_PC = 0, en_IFID = 0; en_IDEX, en_EXMEM, en_MEMWB = 1; bubble_IDEX = 1. The stall lasts exactly 1 cycle, because the load then moves to MEM and lu clears.
  - normal: all en_* = 1; flush_IFID = 0; bubble_IDEX = 0.
- Forwarding is combinational and independent of freeze:
  - fwdA_EX = 10 if RegWrite_MEM & Rd_addr_MEM != 0 & Rd_addr_MEM == Rs1_addr_EX.
  - Else 01 if the same test passes with the WB signals.
  - Else 00. MEM has priority over WB.
  - fwdB_EX is the same, using Rs2_addr_EX.
- FSM transitions:
  - RUN → MEM_WAIT when mem_req_MEM & ~mem_ready; wait_cnt ← 1.
  - MEM_WAIT → RUN on mem_ready. That cycle is not frozen; wait_cnt ← 0.
  - MEM_WAIT, no ready: wait_cnt++. When wait_cnt == TIMEOUT-1 at the clock edge, go to ERROR and set mem_timeout ← 1.
  - If mem_ready arrives on the same cycle the limit is reached, ready wins and the FSM returns to RUN.
  - ERROR is held until rst_IDEX; the pipeline stays frozen.
- Counters, per clock edge:
  - stall_cnt increments on a cycle where lu is the winning action.
  - flush_cnt increments on a branch-flush cycle.
  - freeze_cnt increments on a freeze cycle.
  - Each saturates at 2^CW-1.
  - clr_cnt = 1 zeroes all three and takes priority over increment.
- Reset mid-wait: immediate return to RUN, freeze deasserts combinationally, counters cleared.

Decomposition:
- Shared package holds:
  - FSM state encoding (RUN = 2'd0, MEM_WAIT = 2'd1, ERROR = 2'd2).
  - Forwarding select constants FWD_RF / FWD_MEM / FWD_WB.
  - LOAD_SEL as the MemtoReg encoding.
- Sub-module fwd_unit: purely combinational forwarding compare, instantiated once.
- The FSM, priority logic and counters stay in hazard_ctrl.

Test Plan:
- Load-use: EX holds a load with Rd = 5, MemtoReg = 01, RegWrite = 1; ID has Rs1 = 5, used = 1.
  → 1 cycle with en_PC = 0, en_IFID = 0, bubble_IDEX = 1; next cycle all en = 1; stall_cnt = 1.
- Load to x0: same as above but Rd = 0 and Rs1 = 0 → no stall; all en = 1; stall_cnt stays 0.
- Branch while load-use: Branch_taken_EX = 1 in the same cycle as the lu condition.
  → flush_IFID = 1, bubble_IDEX = 1, en_PC = 1; flush_cnt = 1; stall_cnt = 0.
- Memory wait: mem_req_MEM = 1, mem_ready = 0 for 3 cycles, then 1.
  → all en = 0 for 3 cycles, then resume; freeze_cnt = 3; state returns to RUN.
- Timeout: TIMEOUT = 4, mem_ready held at 0.
  → mem_timeout = 1 after the 4th wait cycle; pipeline stays frozen; rst_IDEX clears the flag and all counters.
- Forwarding: Rs1_EX = 7 matches both MEM Rd = 7 and WB Rd = 7, with both RegWrite = 1 → fwdA_EX = 10. Rs2_EX = 3 matches WB Rd = 3 only → fwdB_EX = 01.
